// File: rtl/tlc_rr_phases_if.sv
// Light colour/state types and the tlc_rr_phases signal bundle.
// master: controller side (lights out, requests in); slave: environment side.
package light_package;

    typedef enum logic [1:0] {
        red    = 2'd0,
        yellow = 2'd1,
        green  = 2'd2
    } colors;

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } tlc_st_t;

endpackage

interface tlc_rr_phases_if #(
    parameter int NPH = 5,
    parameter int PW  = (NPH > 1) ? $clog2(NPH) : 1
);
    import light_package::*;

    logic [NPH-1:0]  phase_req;
    colors [NPH-1:0] phase_light;
    logic [PW-1:0]   cur_phase;
    logic [1:0]      tlc_state;
`ifdef TLC_PREEMPT_EN
    logic            preempt;
    logic [PW-1:0]   preempt_phase;
`endif

    modport master (
        output phase_light, cur_phase, tlc_state,
`ifdef TLC_PREEMPT_EN
        input  preempt, preempt_phase,
`endif
        input  phase_req
    );

    modport slave (
        input  phase_light, cur_phase, tlc_state,
`ifdef TLC_PREEMPT_EN
        output preempt, preempt_phase,
`endif
        output phase_req
    );

endinterface

// File: rtl/tlc_rr_phases.sv
// N-phase round-robin traffic light controller (vacancy/max-green timing).
// Ports: clk, reset (sync, active-low), bus (master): phase_req in,
// phase_light/cur_phase/tlc_state out. `TLC_PREEMPT_EN adds
// bus.preempt/bus.preempt_phase inputs for pre-emption.
module tlc_rr_phases #(
    parameter int NPH     = 5,
    parameter int YEL_CYC = 2,
    parameter int RED_CYC = 1,
    parameter int IDLE_TO = 5,
    parameter int MAX_GRN = 10,
    parameter int CW      = 8
) (
    input  logic           clk,
    input  logic           reset,
    tlc_rr_phases_if.master bus
);
    import light_package::*;

    localparam int PW = (NPH > 1) ? $clog2(NPH) : 1;

    localparam logic [CW-1:0] YEL_M1 = CW'(YEL_CYC - 1);
    localparam logic [CW-1:0] RED_M1 = CW'(RED_CYC - 1);
    localparam logic [CW-1:0] IDL_M1 = CW'(IDLE_TO - 1);
    localparam logic [CW-1:0] MXG_M1 = CW'(MAX_GRN - 1);
    localparam logic [PW-1:0] LAST   = PW'(NPH - 1);

    tlc_st_t       st_q, st_d;
    logic [PW-1:0] cur_q, cur_d;
    logic [CW-1:0] vac_q, vac_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] ytmr_q, ytmr_d;
    logic [CW-1:0] rtmr_q, rtmr_d;

    logic          own_req, oth_req;
    logic          vac_on, occ_on;
    logic          grn_exit, red_ok;
    logic          arb_hit;
    logic [PW-1:0] arb_sel;
    logic          pre_on, pre_hold, pre_kick;
    logic [PW-1:0] pre_ph;
    colors [NPH-1:0] lights;

    // base + off modulo NPH; off is 1..NPH so a single subtract suffices
    function automatic logic [PW-1:0] step_ph(
        input logic [PW-1:0] base,
        input int            off
    );
        int s;
        s = int'(base) + off;
        if (s >= NPH) s = s - NPH;
        return PW'(s);
    endfunction

`ifdef TLC_PREEMPT_EN
    assign pre_ph = bus.preempt_phase;
    assign pre_on = bus.preempt && (int'(bus.preempt_phase) < NPH);
`else
    assign pre_ph = '0;
    assign pre_on = 1'b0;
`endif

    assign pre_hold = pre_on && (pre_ph == cur_q);
    assign pre_kick = pre_on && (pre_ph != cur_q);

    assign own_req = bus.phase_req[cur_q];
    assign oth_req = |(bus.phase_req & ~(NPH'(1) << cur_q));

    // once a counter has started it keeps running whatever the sensors do
    assign vac_on = !own_req || (vac_q != '0);
    assign occ_on = (own_req && oth_req) || (occ_q != '0);

    assign grn_exit = (vac_on && (vac_q >= IDL_M1))
                   || (occ_on && (occ_q >= MXG_M1));

    assign red_ok = (rtmr_q >= RED_M1);

    // nearest requester after cur_q wins; cur_q itself is checked last
    always_comb begin
        arb_hit = 1'b0;
        arb_sel = cur_q;
        for (int i = NPH; i >= 1; i--) begin
            if (bus.phase_req[step_ph(cur_q, i)]) begin
                arb_hit = 1'b1;
                arb_sel = step_ph(cur_q, i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q   <= ALLRED;
            cur_q  <= LAST;
            vac_q  <= '0;
            occ_q  <= '0;
            ytmr_q <= '0;
            rtmr_q <= RED_M1;
        end else begin
            st_q   <= st_d;
            cur_q  <= cur_d;
            vac_q  <= vac_d;
            occ_q  <= occ_d;
            ytmr_q <= ytmr_d;
            rtmr_q <= rtmr_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        cur_d  = cur_q;
        vac_d  = vac_q;
        occ_d  = occ_q;
        ytmr_d = '0;
        rtmr_d = rtmr_q;
        unique case (st_q)
            GREEN: begin
                if (pre_kick || (!pre_hold && grn_exit)) begin
                    st_d  = YELLOW;
                    vac_d = '0;
                    occ_d = '0;
                end else if (!pre_hold) begin
                    if (vac_on && (vac_q != '1))
                        vac_d = vac_q + CW'(1);
                    if (occ_on && (occ_q != '1))
                        occ_d = occ_q + CW'(1);
                end
            end
            YELLOW: begin
                if (ytmr_q >= YEL_M1) begin
                    st_d   = ALLRED;
                    rtmr_d = '0;
                end else begin
                    ytmr_d = ytmr_q + CW'(1);
                end
            end
            default: begin
                if (!red_ok) begin
                    rtmr_d = rtmr_q + CW'(1);
                end else if (pre_on) begin
                    st_d  = GREEN;
                    cur_d = pre_ph;
                end else if (arb_hit) begin
                    st_d  = GREEN;
                    cur_d = arb_sel;
                end
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NPH; i++) lights[i] = red;
        unique case (1'b1)
            (st_q == GREEN):  lights[cur_q] = green;
            (st_q == YELLOW): lights[cur_q] = yellow;
            default: ;
        endcase
    end

    assign bus.phase_light = lights;
    assign bus.cur_phase   = cur_q;
    assign bus.tlc_state   = st_q;

endmodule

// File: doc/tlc_rr_phases.md
Name: tlc_rr_phases

Overview:
- Parametrised N-phase traffic light controller. Successor to the fixed 5-direction controller.
- Each phase is one compatible group of movements (e.g. ES+WS, ES+EL, WS+WL, EL+WL, NS) and has one aggregated sensor request.
- Serves phases round-robin with programmable yellow, all-red, vacancy-timeout and max-green durations.
- Drives one colors-typed light per phase (red/yellow/green from light_package).

Parameters:
- NPH, 5, number of phases (2..16)
- YEL_CYC, 2, yellow duration in cycles (>=1)
- RED_CYC, 1, minimum all-red duration in cycles (>=1)
- IDLE_TO, 5, green cycles after own request first absent
- MAX_GRN, 10, green cycles once conflicting demand is seen
- CW, 8, timer width; IDLE_TO, MAX_GRN, YEL_CYC, RED_CYC must each be < 2^CW

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- phase_req  input  NPH  per-phase traffic sensor (OR of that phase's sensors)
- phase_light  output  NPH x colors  light per phase
- cur_phase  output  PW=max(1,$clog2(NPH))  phase green/yellow, or last served phase while all-red
- tlc_state  output  2  0=ALLRED, 1=GREEN, 2=YELLOW

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (any cycle, including mid-green or mid-yellow) forces:
  - all lights red, state ALLRED, cur_phase=NPH-1;
  - vac=occ=ytmr=0;
  - red timer marked expired, so arbitration happens on the first cycle after reset deasserts.
- Lights are Moore outputs decoded from registered state.
  - GREEN: phase_light[cur_phase]=green.
  - YELLOW: phase_light[cur_phase]=yellow.
  - All other lights red in every state; never two non-red lights.
- GREEN, phase k, each cycle:
  - if !phase_req[k] or vac>0: vac<=vac+1 (saturating);
  - if (phase_req[k] and any other req) or occ>0: occ<=occ+1 (saturating);
  - once started, vac and occ keep counting regardless of later request changes;
  - exit to YELLOW when vac>=IDLE_TO-1 or occ>=MAX_GRN-1;
  - green duration is therefore exactly IDLE_TO cycles from the first vacant cycle, or MAX_GRN cycles from the first conflict cycle, whichever ends first.
- Leaving GREEN clears vac and occ.
- YELLOW lasts exactly YEL_CYC cycles, then ALLRED with the red timer cleared.
- ALLRED:
  - lasts at least RED_CYC cycles;
  - on its last cycle and every later cycle, arbitrate;
  - arbitration searches cur_phase+1, +2, ... modulo NPH, ending at cur_phase itself (lowest priority);
  - the first requesting phase becomes GREEN next cycle and cur_phase updates;
  - with no requests, stay ALLRED indefinitely with cur_phase held.
- A request that toggles during yellow or all-red only matters as sampled at arbitration.
- Phase index wrap: NPH-1 -> 0. Non-power-of-2 NPH must never select an index >= NPH.

Optional Feature:
- Macro: TLC_PREEMPT_EN.
- Defined: adds inputs preempt (1 bit) and preempt_phase (PW bits, values >= NPH ignored).
  - GREEN of a phase != preempt_phase with preempt=1: go to YELLOW next cycle.
  - ALLRED arbitration cycle with preempt=1: select preempt_phase regardless of requests.
  - GREEN of preempt_phase: hold green; vac and occ frozen while preempt=1.
  - Yellow and all-red are never shortened.
- Undefined: ports absent; behaviour exactly as above.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-green of phase 2 -> all red, tlc_state=0, cur_phase=4. Release with phase_req=00001 -> phase_light[0]=green after the first edge with reset=1.
- Vacancy: phase 0 green, phase_req=0 from green cycle 0 -> exactly 5 green, 2 yellow, 1 all-red cycles, then ALLRED held indefinitely with cur_phase=0.
- Max green: phase_req=00011 constant -> phase 0 green 10 cycles, yellow 2, red 1, then phase 1 green 10 cycles, then phase 0 again.
- Round-robin: last served phase 2, phase_req=00101 at arbitration -> phase 0 selected, not phase 2. Last served 4 with phase_req=10000 -> phase 4 re-served after 1 all-red cycle.
- Parametrised: NPH=3, YEL_CYC=3, RED_CYC=2, phase_req=111 -> order 0,1,2,0; 3 yellow and 2 all-red cycles between greens; cur_phase never 3.
- TLC_PREEMPT_EN: phase 1 green at occ=2, preempt=1 with preempt_phase=3 -> 2 yellow cycles, 1 all-red cycle, then phase 3 green held while preempt=1 (phase_req[3]=0), released 5 cycles after preempt drops.
